// File: rtl/uart_pkg.sv
// Shared UART link definitions: receiver state encoding and default frame constants.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous pins; both stages reset to 1 (idle-high line).
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver, LSB first, idle-high line; 8N1 by default.
// Define UART_RX_PARITY_EN to add an even-parity bit, the PARITY state and the parity_err port.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = UART_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
    $error("uart_receiver: CLKS_PER_BIT must be even and >= 4");
  end

  uart_rx_state_e       r_state;
  logic [CW-1:0]        r_clk_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rx_prev;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 w_rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_mis;
  logic                 r_parity_err;
`endif

  uart_sync2 u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(rx),
    .o_sync (w_rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_rx_prev   <= 1'b1;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_mis    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_prev   <= w_rx_s;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // Edge-triggered start so a held-low (break) line cannot retrigger
          if (r_rx_prev && !w_rx_s) begin
            r_clk_cnt <= '0;
            r_state   <= START;
          end
        end
        START: begin
          if (r_clk_cnt == HALF_M1) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_mis <= 1'b0;
`endif
            r_state   <= w_rx_s ? IDLE : DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= PARITY;
`else
              r_state   <= STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            r_par_mis <= (w_rx_s != ^r_shift);
            r_state   <= STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          // Leaving at mid-stop-bit lets an immediately following start edge be caught
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            r_data    <= r_shift;
            r_state   <= IDLE;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= r_par_mis;
            r_valid      <= w_rx_s && !r_par_mis;
`else
            r_valid      <= w_rx_s;
`endif
            r_frame_err <= !w_rx_s;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames against an event-queue model.
module tb_uart_receiver;

  localparam int unsigned CPB = 16;
  localparam int unsigned DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = DB + 1;
`else
  localparam int unsigned NBITS = DB;
`endif
  // pin->rx_s (2) + half bit + payload/parity bits + stop + output register
  localparam int unsigned LAT = 2 + CPB / 2 + (NBITS + 1) * CPB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  kind;   // {parity_err, frame_err, valid}
    logic [7:0]  d;
  } ev_t;
  ev_t exp_q[$];

  uart_receiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [2:0] p;
    ev_t e;
    p = {parity_err, frame_err, valid};
    if (p != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(p), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(p), 32'(e.kind));
        check("pulse_time", cyc, e.cyc);
        check("pulse_data", 32'(data), 32'(e.d));
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    tick(n);
  endtask

  // Model: outcome decided by stop bit and parity rule, timing by fixed frame latency
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    ev_t e;
    e.cyc = cyc + LAT;
    e.d   = d;
`ifdef UART_RX_PARITY_EN
    begin
      logic bad_par;
      bad_par = (par != ^d);
      if (stop) e.kind = bad_par ? 3'b100 : 3'b001;
      else      e.kind = {bad_par, 2'b10};
    end
`else
    e.kind = stop ? 3'b001 : 3'b010;
`endif
    exp_q.push_back(e);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit(par);
`endif
    hold_bit(stop);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    int unsigned ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return logic'(ones % 2);
  endfunction

  logic [7:0] last_d;

  initial begin
    tick(3);
    check("rst_data", 32'(data), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(5);

    send_frame(8'hA5, even_par(8'hA5), 1'b1);
    idle(4);

    // false start: 5-cycle glitch
    rx = 1'b0;
    tick(5);
    check("false_start_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    tick(10);
    check("false_start_idle", 32'(busy), 32'd0);
    idle(10);

    // framing error then break hold
    send_frame(8'h3C, even_par(8'h3C), 1'b0);
    rx = 1'b0;
    tick(50);
    check("break_no_retrigger", 32'(busy), 32'd0);
    tick(50);
    idle(4);
    send_frame(8'h81, even_par(8'h81), 1'b1);

    // back-to-back with one stop bit
    send_frame(8'h00, even_par(8'h00), 1'b1);
    send_frame(8'hFF, even_par(8'hFF), 1'b1);
    idle(8);

    // reset during data bit 4 of 0x55
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(logic'((8'h55 >> i) & 8'h01));
    rx = 1'b1;
    tick(8);
    rst = 1'b1;
    #1;
    check("abort_data", 32'(data), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_frame_err", 32'(frame_err), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    tick(3);
    rst = 1'b0;
    idle(20);
    send_frame(8'h12, even_par(8'h12), 1'b1);
    idle(4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    send_frame(8'h07, 1'b0, 1'b1);
    idle(4);
`endif

    last_d = 8'h12;
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic       stop;
      logic       par;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = even_par(d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, par, stop);
      last_d = d;
      // a low stop bit needs the line to go high before the next start edge
      idle(stop ? $urandom_range(0, 20) : $urandom_range(1, 20));
    end

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
    check("pending_events", exp_q.size(), 32'd0);
    idle(20);
    check("data_holds", 32'(data), 32'(last_d));
    check("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
